// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES datapath constants and types. Holds the block
//                width, the round-key bank depth for each key size, the
//                block type and the state encoding of the 2-entry skid
//                buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES128_NUM_KEYS = 11;
    localparam int AES192_NUM_KEYS = 13;
    localparam int AES256_NUM_KEYS = 15;

    typedef logic [127:0] aes_block_t;

    // EMPTY: nothing held, ONE: main entry holds a block,
    // FULL: main and skid entries both hold a block.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : aes_skid_buf
//  Description : Generic 2-entry valid/ready skid buffer with a registered
//                in_ready. Blocks leave in arrival order. flush empties the
//                buffer and drops any input offered in the same cycle.
//  Ports       : clk, rst_n (async, active low), flush
//                in_valid / in_ready / in_data   - upstream handshake
//                out_valid / out_ready / out_data - downstream handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_skid_buf
    import aes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_nxt = in_data;
                    end else if (w_in_xfer) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = FULL;
                    end else if (w_out_xfer) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_xfer) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ONE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered ready: looks ahead at the state being entered.
            r_in_ready <= (w_state_nxt != FULL);
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
        end
    end

endmodule : aes_skid_buf
`default_nettype wire

// File: rtl/aes_add_round_key_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : aes_add_round_key_pipe
//  Description : Pipelined AES AddRoundKey stage. Holds NUM_KEYS round keys
//                and XORs each accepted block with the key chosen by its
//                round index. Out-of-range indices use a zero key and flag
//                out_err. Results are held in a 2-entry skid buffer.
//  Ports       : clk, rst_n (async, active low), flush
//                key_wr_en / key_wr_idx / key_wr_data - key bank write port
//                in_valid / in_ready / in_data / in_idx - block input
//                out_valid / out_ready / out_data / out_idx / out_err
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_add_round_key_pipe
    import aes_pkg::*;
#(
    parameter int DATA_W   = AES_BLOCK_W,
    parameter int NUM_KEYS = AES128_NUM_KEYS,
    parameter int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_err
);

    localparam int c_lanes = DATA_W / 8;
    localparam int c_pay_w = DATA_W + IDX_W + 1;

    logic [DATA_W-1:0]  r_key [NUM_KEYS];
    logic [DATA_W-1:0]  w_key;
    logic               w_hit;
    logic [DATA_W-1:0]  w_xor;
    logic [c_pay_w-1:0] w_pay_in;
    logic [c_pay_w-1:0] w_pay_out;

    // Key bank. An index with no matching entry (>= NUM_KEYS) writes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_key[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_wr_en && (key_wr_idx == k[IDX_W-1:0])) begin
                    r_key[k] <= key_wr_data;
                end
            end
        end
    end

    // Key read. Reading the registered bank means a same-cycle write to the
    // selected index is not yet visible: the block sees the old key.
    always_comb begin
        w_key = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (in_idx == k[IDX_W-1:0]) begin
                w_key = r_key[k];
                w_hit = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
        assign w_xor[8*i +: 8] = in_data[8*i +: 8] ^ w_key[8*i +: 8];
    end

    assign w_pay_in = {~w_hit, in_idx, w_xor};

    aes_skid_buf #(
        .WIDTH (c_pay_w)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_pay_out)
    );

    assign out_data = w_pay_out[DATA_W-1:0];
    assign out_idx  = w_pay_out[DATA_W +: IDX_W];
    assign out_err  = w_pay_out[c_pay_w-1];

endmodule : aes_add_round_key_pipe
`default_nettype wire
